// File: rtl/dmem_arbiter.sv
// Two-port arbiter sharing a single-port data RAM between the CPU data port (0)
// and a secondary master (1); round-robin or fixed priority, with per-port lock.
module dmem_arbiter #(
    parameter int AW         = 8,
    parameter int DW         = 32,
    parameter int ARB_MODE   = 0,
    parameter int STARVE_MAX = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          m0_req,
    input  logic [3:0]    m0_we,
    input  logic [AW-1:0] m0_addr,
    input  logic [DW-1:0] m0_wdata,
    input  logic          m0_lock,
    output logic          m0_gnt,
    output logic          m0_rvalid,
    output logic [DW-1:0] m0_rdata,
    input  logic          m1_req,
    input  logic [3:0]    m1_we,
    input  logic [AW-1:0] m1_addr,
    input  logic [DW-1:0] m1_wdata,
    input  logic          m1_lock,
    output logic          m1_gnt,
    output logic          m1_rvalid,
    output logic [DW-1:0] m1_rdata,
    output logic          ram_en,
    output logic [3:0]    ram_we,
    output logic [AW-1:0] ram_addr,
    output logic [DW-1:0] ram_wdata,
    input  logic [DW-1:0] ram_rdata
);

    localparam int SW_CLOG = $clog2(STARVE_MAX + 1);
    localparam int SW      = (SW_CLOG > 3) ? SW_CLOG : 3;
    localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);
    localparam logic ROUND_ROBIN = (ARB_MODE == 0);

    logic          last;
    logic          lock_q;
    logic          lock_own;
    logic [SW-1:0] starve_cnt;
    logic          rv0_q;
    logic          rv1_q;

    logic owner_req;
    logic lock_hold;
    logic gnt_any;
    logic win1;

    // A lock whose owner stops requesting falls through to normal arbitration,
    // which then only sees the other port.
    always_comb begin
        owner_req = lock_own ? m1_req : m0_req;
        lock_hold = lock_q & owner_req;
        gnt_any   = 1'b0;
        win1      = 1'b0;
        if (lock_hold) begin
            gnt_any = 1'b1;
            win1    = lock_own;
        end else if (m0_req && m1_req) begin
            gnt_any = 1'b1;
            win1    = ROUND_ROBIN ? ~last : (starve_cnt == STARVE_LIM);
        end else if (m0_req || m1_req) begin
            gnt_any = 1'b1;
            win1    = m1_req;
        end
        if (!rst) begin
            gnt_any = 1'b0;
        end
    end

    assign m0_gnt    = gnt_any & ~win1;
    assign m1_gnt    = gnt_any & win1;
    assign ram_en    = gnt_any;
    assign ram_addr  = win1 ? m1_addr : m0_addr;
    assign ram_wdata = win1 ? m1_wdata : m0_wdata;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_we
            assign ram_we[gi] = gnt_any & (win1 ? m1_we[gi] : m0_we[gi]);
        end
    endgenerate

    assign m0_rdata  = ram_rdata;
    assign m1_rdata  = ram_rdata;
    assign m0_rvalid = rv0_q;
    assign m1_rvalid = rv1_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            last       <= 1'b1;
            lock_q     <= 1'b0;
            lock_own   <= 1'b0;
            starve_cnt <= '0;
            rv0_q      <= 1'b0;
            rv1_q      <= 1'b0;
        end else begin
            rv0_q <= m0_gnt && (m0_we == 4'h0);
            rv1_q <= m1_gnt && (m1_we == 4'h0);
            if (gnt_any) begin
                last     <= win1;
                lock_own <= win1;
                lock_q   <= win1 ? m1_lock : m0_lock;
            end else begin
                lock_q <= 1'b0;
            end
            if (m0_gnt && m1_req) begin
                if (starve_cnt != STARVE_LIM) begin
                    starve_cnt <= starve_cnt + 1'b1;
                end
            end else if (m1_gnt || !m1_req) begin
                starve_cnt <= '0;
            end
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: a round-robin instance backed by a small
// write-first RAM model, plus a fixed-priority instance for the starvation pattern.
module tb_dmem_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        m0_req, m1_req, m0_lock, m1_lock;
    logic [3:0]  m0_we, m1_we;
    logic [7:0]  m0_addr, m1_addr;
    logic [31:0] m0_wdata, m1_wdata;
    logic        m0_gnt, m1_gnt, m0_rvalid, m1_rvalid;
    logic [31:0] m0_rdata, m1_rdata;
    logic        ram_en;
    logic [3:0]  ram_we;
    logic [7:0]  ram_addr;
    logic [31:0] ram_wdata, ram_rdata, merged;
    logic [31:0] mem [0:255];

    logic        f0_req, f1_req;
    logic        f0_gnt, f1_gnt, f0_rvalid, f1_rvalid, f_en;
    logic [31:0] f0_rdata, f1_rdata, f_wdata;
    logic [3:0]  f_we;
    logic [7:0]  f_addr;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    dmem_arbiter #(.AW(8), .DW(32), .ARB_MODE(0), .STARVE_MAX(4)) u_rr (
        .clk(clk), .rst(rst),
        .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_lock(m0_lock),
        .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
        .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_lock(m1_lock),
        .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
        .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
        .ram_rdata(ram_rdata)
    );

    dmem_arbiter #(.AW(8), .DW(32), .ARB_MODE(1), .STARVE_MAX(4)) u_fp (
        .clk(clk), .rst(rst),
        .m0_req(f0_req), .m0_we(4'h0), .m0_addr(8'h01), .m0_wdata(32'h0), .m0_lock(1'b0),
        .m0_gnt(f0_gnt), .m0_rvalid(f0_rvalid), .m0_rdata(f0_rdata),
        .m1_req(f1_req), .m1_we(4'h0), .m1_addr(8'h02), .m1_wdata(32'h0), .m1_lock(1'b0),
        .m1_gnt(f1_gnt), .m1_rvalid(f1_rvalid), .m1_rdata(f1_rdata),
        .ram_en(f_en), .ram_we(f_we), .ram_addr(f_addr), .ram_wdata(f_wdata),
        .ram_rdata(32'h0)
    );

    // Write-first RAM: a read of the word being written returns the merged data.
    always_comb begin
        merged = mem[ram_addr];
        for (int b = 0; b < 4; b++) begin
            if (ram_we[b]) merged[8*b +: 8] = ram_wdata[8*b +: 8];
        end
    end

    always @(posedge clk) begin
        if (ram_en) begin
            mem[ram_addr] <= merged;
            ram_rdata     <= merged;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic wr1(input logic [7:0] a, input logic [31:0] d);
        cyc();
        m1_req = 1'b1; m1_we = 4'hF; m1_addr = a; m1_wdata = d;
        @(negedge clk);
        chk("preload_gnt", m1_gnt, 1'b1);
        cyc();
        m1_req = 1'b0; m1_we = 4'h0;
    endtask

    logic [3:0] rr_g1;
    logic [9:0] fp_g1;

    initial begin
        rst = 1'b0;
        m0_req = 0; m1_req = 0; m0_lock = 0; m1_lock = 0;
        m0_we = 0; m1_we = 0; m0_addr = 0; m1_addr = 0; m0_wdata = 0; m1_wdata = 0;
        f0_req = 0; f1_req = 0;
        rr_g1 = 4'b1010;
        fp_g1 = 10'b10000_10000;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;

        wr1(8'h10, 32'hDEADBEEF);
        wr1(8'h11, 32'hCAFEF00D);
        $display("preload 0x10/0x11 done");

        // Reset with requests pending: everything forced off.
        rst = 1'b0; m0_req = 1'b1; m1_req = 1'b1; f0_req = 1'b1;
        #2;
        chk("rst_m0_gnt", m0_gnt, 1'b0);
        chk("rst_m1_gnt", m1_gnt, 1'b0);
        chk("rst_ram_en", ram_en, 1'b0);
        chk("rst_ram_we", ram_we, 4'h0);
        chk("rst_fp_gnt", f0_gnt, 1'b0);
        chk("rst_rvalid", {m0_rvalid, m1_rvalid}, 2'b00);
        cyc();
        m0_req = 0; m1_req = 0; f0_req = 0; rst = 1'b1;
        $display("reset gating checked");

        // Continuous reads from both ports: 0,1,0,1 with rvalid one cycle later.
        cyc();
        m0_req = 1; m0_addr = 8'h10; m1_req = 1; m1_addr = 8'h11;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("rr_m0_gnt", m0_gnt, !rr_g1[k]);
            chk("rr_m1_gnt", m1_gnt, rr_g1[k]);
            if (k > 0) begin
                chk("rr_m0_rvalid", m0_rvalid, !rr_g1[k-1]);
                chk("rr_m1_rvalid", m1_rvalid, rr_g1[k-1]);
                chk("rr_rdata", rr_g1[k-1] ? m1_rdata : m0_rdata,
                    rr_g1[k-1] ? 32'hCAFEF00D : 32'hDEADBEEF);
            end
            $display("rr beat %0d gnt0=%b gnt1=%b", k, m0_gnt, m1_gnt);
        end
        cyc();
        m0_req = 0; m1_req = 0;
        @(negedge clk);
        chk("rr_tail_m1_rvalid", m1_rvalid, 1'b1);
        chk("rr_tail_m0_rvalid", m0_rvalid, 1'b0);
        chk("rr_tail_rdata", m1_rdata, 32'hCAFEF00D);

        // Single port 0 read.
        cyc();
        m0_req = 1; m0_addr = 8'h10;
        @(negedge clk);
        chk("rd_gnt", m0_gnt, 1'b1);
        chk("rd_addr", ram_addr, 8'h10);
        cyc();
        m0_req = 0;
        @(negedge clk);
        chk("rd_rvalid", m0_rvalid, 1'b1);
        chk("rd_rdata", m0_rdata, 32'hDEADBEEF);
        chk("rd_m1_rvalid", m1_rvalid, 1'b0);
        chk("rd_idle_en", ram_en, 1'b0);
        $display("port0 read 0x10 -> %h", m0_rdata);

        // Port 1 write, then port 0 reads it back on the next cycle.
        cyc();
        m1_req = 1; m1_we = 4'hF; m1_addr = 8'h20; m1_wdata = 32'h12345678;
        @(negedge clk);
        chk("wr_gnt", m1_gnt, 1'b1);
        chk("wr_we", ram_we, 4'hF);
        chk("wr_wdata", ram_wdata, 32'h12345678);
        cyc();
        m1_req = 0; m1_we = 0; m0_req = 1; m0_addr = 8'h20;
        @(negedge clk);
        chk("raw_gnt", m0_gnt, 1'b1);
        chk("wr_no_rvalid", m1_rvalid, 1'b0);
        cyc();
        m0_req = 0;
        @(negedge clk);
        chk("raw_rvalid", m0_rvalid, 1'b1);
        chk("raw_rdata", m0_rdata, 32'h12345678);
        $display("write/readback 0x20 -> %h", m0_rdata);

        // Partial-byte write.
        cyc();
        m1_req = 1; m1_we = 4'b0011; m1_addr = 8'h20; m1_wdata = 32'hAAAA5555;
        @(negedge clk);
        chk("pw_we", ram_we, 4'b0011);
        cyc();
        m1_req = 0; m1_we = 0; m0_req = 1; m0_addr = 8'h20;
        cyc();
        m0_req = 0;
        @(negedge clk);
        chk("pw_rdata", m0_rdata, 32'h12345555);
        $display("partial write 0x20 -> %h", m0_rdata);

        // Port 1 lock for three beats against a waiting port 0.
        cyc();
        m0_req = 1; m0_addr = 8'h10; m1_req = 1; m1_addr = 8'h11; m1_lock = 1;
        @(negedge clk);
        chk("lk_b0_m1", m1_gnt, 1'b1);
        chk("lk_b0_m0", m0_gnt, 1'b0);
        cyc();
        @(negedge clk);
        chk("lk_b1_m1", m1_gnt, 1'b1);
        cyc();
        m1_lock = 0;
        @(negedge clk);
        chk("lk_b2_m1", m1_gnt, 1'b1);
        cyc();
        @(negedge clk);
        chk("lk_b3_m0", m0_gnt, 1'b1);
        chk("lk_b3_m1", m1_gnt, 1'b0);
        cyc();
        m0_req = 0; m1_req = 0;
        $display("lock sequence checked");

        // Fixed priority with starvation limit 4.
        f0_req = 1; f1_req = 1;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            chk("fp_m0_gnt", f0_gnt, !fp_g1[k]);
            chk("fp_m1_gnt", f1_gnt, fp_g1[k]);
            $display("fp beat %0d gnt0=%b gnt1=%b", k, f0_gnt, f1_gnt);
        end
        cyc();
        f0_req = 0; f1_req = 0;

        // Reset in the cycle after a port 0 read grant.
        m0_req = 1; m0_addr = 8'h10;
        @(negedge clk);
        chk("ar_gnt", m0_gnt, 1'b1);
        cyc();
        m0_req = 0;
        chk("ar_rvalid_pre", m0_rvalid, 1'b1);
        rst = 1'b0;
        #1;
        chk("ar_rvalid_drop", m0_rvalid, 1'b0);
        cyc();
        rst = 1'b1; m0_req = 1; m1_req = 1;
        @(negedge clk);
        chk("ar_first_m0", m0_gnt, 1'b1);
        chk("ar_first_m1", m1_gnt, 1'b0);
        chk("ar_no_stale", m0_rvalid, 1'b0);
        cyc();
        m0_req = 0; m1_req = 0;
        @(negedge clk);
        chk("ar_new_rvalid", m0_rvalid, 1'b1);
        $display("async reset mid-read checked");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
